// File: rtl/mem_arbiter.sv
// Three-master arbiter (dbg > dmem/imem round-robin) in front of a single-port RAM
// with a fixed read latency; one outstanding read at a time.
module mem_arbiter #(
    parameter int RAM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    input  logic [3:0]  dbg_wstrb,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,

    input  logic        dmem_req,
    input  logic        dmem_we,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic        dmem_gnt,
    output logic        dmem_rvalid,

    input  logic        imem_req,
    input  logic        imem_we,
    input  logic [31:0] imem_addr,
    input  logic [31:0] imem_wdata,
    input  logic [3:0]  imem_wstrb,
    output logic        imem_gnt,
    output logic        imem_rvalid,

    output logic [31:0] rdata,

    input  logic        dbg_hold,

    output logic        ram_en,
    output logic [3:0]  ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    typedef enum logic {IDLE, WAIT} state_t;
    typedef enum logic [1:0] {
        OWN_DBG  = 2'd0,
        OWN_DMEM = 2'd1,
        OWN_IMEM = 2'd2,
        OWN_NONE = 2'd3
    } owner_t;

    localparam logic [2:0] LAT = 3'(RAM_LAT);

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    owner_t      own, own_nxt;
    logic        pref_imem, pref_imem_nxt;

    logic        rd_done;
    logic        accept;
    owner_t      win;
    logic        win_we;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;
    logic [3:0]  win_wstrb;

    assign rd_done = (state == WAIT) && (cnt == LAT);
    // Gating with rst keeps the combinational grant path quiet during reset.
    assign accept  = !rst && ((state == IDLE) || rd_done);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        win = OWN_NONE;
        if (accept) begin
            if (dbg_req) begin
                win = OWN_DBG;
            end else if (!dbg_hold) begin
                if (dmem_req && imem_req) win = pref_imem ? OWN_IMEM : OWN_DMEM;
                else if (dmem_req)        win = OWN_DMEM;
                else if (imem_req)        win = OWN_IMEM;
            end
        end
    end

    always_comb begin
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        win_wstrb = '0;
        unique case (win)
            OWN_DBG:  begin win_we = dbg_we;  win_addr = dbg_addr;  win_wdata = dbg_wdata;  win_wstrb = dbg_wstrb;  end
            OWN_DMEM: begin win_we = dmem_we; win_addr = dmem_addr; win_wdata = dmem_wdata; win_wstrb = dmem_wstrb; end
            OWN_IMEM: begin win_we = imem_we; win_addr = imem_addr; win_wdata = imem_wdata; win_wstrb = imem_wstrb; end
            default:  ;
        endcase
    end

    // NOTE: reset is asynchronous so a read in flight is dropped the instant rst rises.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            own       <= OWN_DMEM;
            pref_imem <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            own       <= own_nxt;
            pref_imem <= pref_imem_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        own_nxt       = own;
        pref_imem_nxt = pref_imem;
        if (win != OWN_NONE && !win_we) begin
            state_nxt = WAIT;
            cnt_nxt   = 3'd1;
            own_nxt   = win;
        end else if (state == WAIT && !rd_done) begin
            cnt_nxt = cnt + 3'd1;
        end else begin
            state_nxt = IDLE;
            cnt_nxt   = 3'd0;
        end
        // Only dmem/imem grants move the fairness pointer; the loser is preferred next.
        if (win == OWN_DMEM)      pref_imem_nxt = 1'b1;
        else if (win == OWN_IMEM) pref_imem_nxt = 1'b0;
    end

    always_comb begin
        dbg_gnt     = (win == OWN_DBG);
        dmem_gnt    = (win == OWN_DMEM);
        imem_gnt    = (win == OWN_IMEM);
        ram_en      = (win != OWN_NONE);
        ram_we      = (ram_en && win_we) ? win_wstrb : 4'b0000;
        ram_addr    = win_addr;
        ram_wdata   = win_wdata;
        dbg_rvalid  = rd_done && (own == OWN_DBG);
        dmem_rvalid = rd_done && (own == OWN_DMEM);
        imem_rvalid = rd_done && (own == OWN_IMEM);
        rdata       = ram_rdata;
    end

endmodule
